// File: rtl/module_transmisor_hamming_pkg.sv
// Shared definitions for the Hamming SEC-DED link: transmitter FSM states and
// codeword bit positions, used by both the transmit and receive paths.
package pkg_hamming;

    typedef enum logic [1:0] {
        IDLE,
        INICIO,
        DATOS,
        PARADA
    } estado_tx_t;

    // Codeword layout {p0,d4,d3,d2,p4,d1,p2,p1}, bits 7..0
    localparam int IDX_P1 = 0;
    localparam int IDX_P2 = 1;
    localparam int IDX_D1 = 2;
    localparam int IDX_P4 = 3;
    localparam int IDX_D2 = 4;
    localparam int IDX_D3 = 5;
    localparam int IDX_D4 = 6;
    localparam int IDX_P0 = 7;

    localparam int ANCHO_DATOS   = 4;
    localparam int ANCHO_PALABRA = 8;

endpackage

// File: rtl/module_transmisor_hamming_codificador.sv
// Combinational nibble to extended-Hamming (8,4) encoder with even overall
// parity in the top bit.
module module_codificador_hamming
    import pkg_hamming::*;
(
    input  logic [ANCHO_DATOS-1:0]   i_datos,
    output logic [ANCHO_PALABRA-1:0] o_palabra
);

    logic [ANCHO_PALABRA-2:0] w_bajos;

    always_comb begin
        w_bajos         = '0;
        w_bajos[IDX_D1] = i_datos[0];
        w_bajos[IDX_D2] = i_datos[1];
        w_bajos[IDX_D3] = i_datos[2];
        w_bajos[IDX_D4] = i_datos[3];
        w_bajos[IDX_P1] = i_datos[0] ^ i_datos[1] ^ i_datos[3];
        w_bajos[IDX_P2] = i_datos[0] ^ i_datos[2] ^ i_datos[3];
        w_bajos[IDX_P4] = i_datos[1] ^ i_datos[2] ^ i_datos[3];
    end

    // p0 makes the whole 8-bit word even parity (double-error detection)
    assign o_palabra = {^w_bajos, w_bajos};

endmodule

// File: rtl/module_transmisor_hamming.sv
// Hamming (8,4) serial transmitter: start bit, 8 codeword bits LSB first, stop bit.
// Optional macro INYECCION_ERROR_EN adds an XOR error-mask port sampled at transfer.
module module_transmisor_hamming
    import pkg_hamming::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ANCHO_DATOS-1:0]   datos_entrada,
    input  logic                     entrada_valida,
`ifdef INYECCION_ERROR_EN
    input  logic [ANCHO_PALABRA-1:0] inyectar_error,
`endif
    output logic                     entrada_lista,
    output logic                     tx_serie,
    output logic [ANCHO_PALABRA-1:0] palabra_codificada,
    output logic                     ocupado,
    output logic                     fin_trama
);

    // With one cycle per bit the counter would be zero-width; keep one bit
    localparam int ANCHO_CNT = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(CICLOS_POR_BIT - 1);

    estado_tx_t               r_estado, r_estado_next;
    logic [ANCHO_CNT-1:0]     r_cnt, r_cnt_next;
    logic [2:0]               r_indice_bit, r_indice_bit_next;
    logic [ANCHO_PALABRA-1:0] r_palabra, r_palabra_next;
    logic                     r_tx, r_tx_next;
    logic                     r_fin, r_fin_next;

    logic [ANCHO_PALABRA-1:0] w_palabra_cod;
    logic [ANCHO_PALABRA-1:0] w_palabra_tx;
    logic [2:0]               w_indice_sig;

    module_codificador_hamming u_codificador (
        .i_datos   (datos_entrada),
        .o_palabra (w_palabra_cod)
    );

`ifdef INYECCION_ERROR_EN
    assign w_palabra_tx = w_palabra_cod ^ inyectar_error;
`else
    assign w_palabra_tx = w_palabra_cod;
`endif

    assign w_indice_sig = r_indice_bit + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado     <= IDLE;
            r_cnt        <= '0;
            r_indice_bit <= '0;
            r_palabra    <= '0;
            r_tx         <= 1'b1;
            r_fin        <= 1'b0;
        end else begin
            r_estado     <= r_estado_next;
            r_cnt        <= r_cnt_next;
            r_indice_bit <= r_indice_bit_next;
            r_palabra    <= r_palabra_next;
            r_tx         <= r_tx_next;
            r_fin        <= r_fin_next;
        end
    end

    // Line value is computed for the state being entered so tx_serie is a flop
    always_comb begin
        r_estado_next     = r_estado;
        r_cnt_next        = r_cnt;
        r_indice_bit_next = r_indice_bit;
        r_palabra_next    = r_palabra;
        r_tx_next         = r_tx;
        r_fin_next        = 1'b0;

        case (r_estado)
            IDLE: begin
                r_tx_next = 1'b1;
                if (entrada_valida) begin
                    r_palabra_next    = w_palabra_tx;
                    r_cnt_next        = '0;
                    r_indice_bit_next = '0;
                    r_estado_next     = INICIO;
                    r_tx_next         = 1'b0;
                end
            end
            INICIO: begin
                if (r_cnt == CNT_MAX) begin
                    r_cnt_next        = '0;
                    r_indice_bit_next = '0;
                    r_estado_next     = DATOS;
                    r_tx_next         = r_palabra[0];
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end
            DATOS: begin
                if (r_cnt == CNT_MAX) begin
                    r_cnt_next = '0;
                    if (r_indice_bit == 3'd7) begin
                        r_estado_next = PARADA;
                        r_tx_next     = 1'b1;
                    end else begin
                        r_indice_bit_next = w_indice_sig;
                        r_tx_next         = r_palabra[w_indice_sig];
                    end
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end
            PARADA: begin
                r_tx_next = 1'b1;
                if (r_cnt == CNT_MAX) begin
                    r_cnt_next    = '0;
                    r_estado_next = IDLE;
                    r_fin_next    = 1'b1;
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                r_estado_next = IDLE;
                r_tx_next     = 1'b1;
            end
        endcase
    end

    assign entrada_lista      = (r_estado == IDLE);
    assign ocupado            = (r_estado != IDLE);
    assign tx_serie           = r_tx;
    assign palabra_codificada = r_palabra;
    assign fin_trama          = r_fin;

endmodule

// File: tb/tb_module_transmisor_hamming.sv
// Self-checking bench for module_transmisor_hamming: table vectors, random frames
// against a position-based Hamming model, back-to-back, ignored pulse, mid-frame reset.
module tb_module_transmisor_hamming;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] datos_entrada;
    logic       entrada_valida;
    logic       entrada_lista;
    logic       tx_serie;
    logic [7:0] palabra_codificada;
    logic       ocupado;
    logic       fin_trama;
`ifdef INYECCION_ERROR_EN
    logic [7:0] mask_reg;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    module_transmisor_hamming #(.CICLOS_POR_BIT(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .datos_entrada      (datos_entrada),
        .entrada_valida     (entrada_valida),
`ifdef INYECCION_ERROR_EN
        .inyectar_error     (mask_reg),
`endif
        .entrada_lista      (entrada_lista),
        .tx_serie           (tx_serie),
        .palabra_codificada (palabra_codificada),
        .ocupado            (ocupado),
        .fin_trama          (fin_trama)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Classic Hamming: positions 1..7, parity at powers of two covers positions
    // sharing that bit; codeword bit (pos-1); bit 7 is overall even parity.
    function automatic logic [7:0] enc_ref(input logic [3:0] nib);
        logic pos[8];
        int   dpos[4];
        logic [7:0] cw;
        dpos = '{3, 5, 6, 7};
        for (int j = 0; j < 8; j++) pos[j] = 1'b0;
        for (int i = 0; i < 4; i++) pos[dpos[i]] = nib[i];
        for (int k = 1; k <= 4; k = k * 2)
            for (int j = 1; j <= 7; j++)
                if ((j & k) != 0 && j != k) pos[k] = pos[k] ^ pos[j];
        cw = '0;
        for (int j = 1; j <= 7; j++) cw[j-1] = pos[j];
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    // Sends one nibble and follows the whole frame; pulse_at>0 pulses entrada_valida
    // with 4'h5 at that frame cycle to prove it is ignored while busy.
    task automatic send_frame(input logic [3:0] nib, input logic [7:0] exp_cw,
                              input int pulse_at, input string tag);
        int   guard = 0;
        int   serr  = 0;
        int   ferr  = 0;
        logic exp_bit;
        while (!entrada_lista && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, 32'(entrada_lista), 32'd1);
        datos_entrada  = nib;
        entrada_valida = 1'b1;
        @(posedge clk); #1;
        entrada_valida = 1'b0;
        check({tag, " codeword"}, 32'(palabra_codificada), 32'(exp_cw));
        check({tag, " busy"}, {30'd0, ocupado, entrada_lista}, 32'b10);
        for (int k = 1; k <= 41; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k <= N)          exp_bit = 1'b0;
            else if (k <= 9 * N) exp_bit = exp_cw[(k - N - 1) / N];
            else                 exp_bit = 1'b1;
            if (k <= 10 * N) begin
                if (tx_serie !== exp_bit) serr++;
                if (palabra_codificada !== exp_cw) serr++;
                if (fin_trama !== 1'b0 || ocupado !== 1'b1) ferr++;
            end else begin
                check({tag, " fin pulse"}, 32'(fin_trama), 32'd1);
                check({tag, " idle after"}, {29'd0, tx_serie, entrada_lista, ocupado}, 32'b110);
            end
            if (pulse_at > 0 && k == pulse_at) begin
                entrada_valida = 1'b1;
                datos_entrada  = 4'h5;
            end else if (pulse_at > 0 && k == pulse_at + 1) begin
                entrada_valida = 1'b0;
                datos_entrada  = nib;
            end
        end
        check({tag, " serial errs"}, 32'(serr), 32'd0);
        check({tag, " status errs"}, 32'(ferr), 32'd0);
        $display("frame %s nib=%h cw=%h", tag, nib, palabra_codificada);
    endtask

    typedef struct {
        logic [3:0] nib;
        logic [7:0] cw;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [3:0] b2b_nib[3];
        logic [7:0] b2b_cw[3];
        int         t_start[3];
        int         idx;
        logic       prev;
        int         ferr;
        logic [3:0] rn;

        vecs[0] = '{4'hB, 8'h55};
        vecs[1] = '{4'h0, 8'h00};
        vecs[2] = '{4'hF, 8'hFF};
        vecs[3] = '{4'h1, 8'h87};
        vecs[4] = '{4'h2, 8'h99};
        b2b_nib = '{4'h0, 4'hF, 4'h1};
        b2b_cw  = '{8'h00, 8'hFF, 8'h87};

        rst            = 1'b1;
        datos_entrada  = 4'h0;
        entrada_valida = 1'b0;
`ifdef INYECCION_ERROR_EN
        mask_reg       = 8'h00;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        ferr = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (fin_trama !== 1'b0 || tx_serie !== 1'b1) ferr++;
        end
        check("reset tx", 32'(tx_serie), 32'd1);
        check("reset ready", 32'(entrada_lista), 32'd1);
        check("reset busy", 32'(ocupado), 32'd0);
        check("reset codeword", 32'(palabra_codificada), 32'h00);
        check("reset idle errs", 32'(ferr), 32'd0);

        for (int i = 0; i < 5; i++)
            send_frame(vecs[i].nib, vecs[i].cw, 0, $sformatf("table%0d", i));

        // Back-to-back with entrada_valida held high
        idx  = 0;
        prev = ocupado;
        datos_entrada  = b2b_nib[0];
        entrada_valida = 1'b1;
        for (int c = 0; c < 200 && idx < 3; c++) begin
            @(posedge clk); #1;
            if (ocupado && !prev) begin
                t_start[idx] = c;
                check($sformatf("b2b cw%0d", idx), 32'(palabra_codificada), 32'(b2b_cw[idx]));
                idx++;
                if (idx < 3) datos_entrada = b2b_nib[idx];
                else         entrada_valida = 1'b0;
            end
            prev = ocupado;
        end
        check("b2b frames seen", 32'(idx), 32'd3);
        if (idx == 3) begin
            check("b2b spacing1", 32'(t_start[1] - t_start[0]), 32'd41);
            check("b2b spacing2", 32'(t_start[2] - t_start[1]), 32'd41);
        end
        $display("b2b starts %0d %0d %0d", t_start[0], t_start[1], t_start[2]);

        // Pulse while busy must be ignored
        send_frame(4'hB, 8'h55, 10, "pulse_busy");

        // Reset during DATOS bit 3 (frame cycles 17..20)
        datos_entrada  = 4'hB;
        entrada_valida = 1'b1;
        @(posedge clk); #1;
        entrada_valida = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst tx", 32'(tx_serie), 32'd1);
        check("midrst busy", 32'(ocupado), 32'd0);
        check("midrst codeword", 32'(palabra_codificada), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        ferr = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (fin_trama !== 1'b0 || ocupado !== 1'b0 || tx_serie !== 1'b1) ferr++;
        end
        check("midrst quiet errs", 32'(ferr), 32'd0);
        $display("midframe reset done");
        send_frame(4'hB, 8'h55, 0, "after_rst");

`ifdef INYECCION_ERROR_EN
        mask_reg = 8'h04;
        send_frame(4'hB, 8'h51, 0, "inject");
        mask_reg = 8'h00;
`endif

        // Random frames against the reference model
        for (int i = 0; i < 16; i++) begin
            rn = 4'($urandom_range(0, 15));
`ifdef INYECCION_ERROR_EN
            mask_reg = 8'($urandom_range(0, 255));
            send_frame(rn, enc_ref(rn) ^ mask_reg, (i % 2 == 1) ? int'($urandom_range(2, 39)) : 0,
                       $sformatf("rand%0d", i));
`else
            send_frame(rn, enc_ref(rn), (i % 2 == 1) ? int'($urandom_range(2, 39)) : 0,
                       $sformatf("rand%0d", i));
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/module_transmisor_hamming.md
# module_transmisor_hamming

Transmit-side counterpart of the SEC-DED receive path: accepts a 4-bit data nibble over a valid/ready handshake and encodes it into an 8-bit extended Hamming codeword. The codeword is laid out as {p0,d4,d3,d2,p4,d1,p2,p1}, bits 7..0. It is then shifted out on a single serial line with start and stop bits. The block sits between the data source and the link whose far end feeds the syndrome detector and error corrector.

## Interface
- CICLOS_POR_BIT, default 4: clock cycles per serial bit; legal range ≥1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- datos_entrada  input  4  nibble to send; d1=bit0, d2=bit1, d3=bit2, d4=bit3.
- entrada_valida  input  1  source holds a valid nibble.
- entrada_lista  output  1  block can accept a nibble this cycle.
- inyectar_error  input  8  XOR error mask; present only with INYECCION_ERROR_EN.
- tx_serie  output  1  serial line; idle high.
- palabra_codificada  output  8  codeword of the frame in flight or the last frame sent.
- ocupado  output  1  frame in progress.
- fin_trama  output  1  one-cycle pulse after each completed frame.

## Operation
- Encoding:
  - p1 = d1^d2^d4; p2 = d1^d3^d4; p4 = d2^d3^d4.
  - p0 = XOR of bits 0..6, giving even overall parity.
  - Bit order: bit0=p1, bit1=p2, bit2=d1, bit3=p4, bit4=d2, bit5=d3, bit6=d4, bit7=p0.
- Handshake:
  - Transfer occurs on a rising edge where entrada_valida and entrada_lista are both 1.
  - entrada_lista = 1 exactly when the state is IDLE.
  - entrada_valida outside IDLE is ignored; the source holds its data until the transfer.
- State machine IDLE → INICIO → DATOS → PARADA → IDLE:
  - IDLE: tx_serie=1. On transfer, register the codeword into palabra_codificada, clear the counters, go to INICIO.
  - INICIO: tx_serie=0 for CICLOS_POR_BIT cycles, then DATOS.
  - DATOS: tx_serie = palabra_codificada[indice_bit], sent LSB first.
    - indice_bit counts 0..7; each bit lasts CICLOS_POR_BIT cycles.
    - After bit 7, go to PARADA.
  - PARADA: tx_serie=1 for CICLOS_POR_BIT cycles, then IDLE. fin_trama=1 in the first IDLE cycle.
- Outputs:
  - ocupado = 1 in INICIO, DATOS and PARADA.
  - tx_serie is registered (no combinational glitches).
- Reset values:
  - State IDLE, so entrada_lista=1.
  - tx_serie=1, palabra_codificada=8'h00, ocupado=0, fin_trama=0, counters 0.
- Reset mid-frame: the frame is aborted immediately (asynchronously), the line returns high, and no fin_trama is produced.

## Timing
- Codeword is visible on palabra_codificada the cycle after the transfer edge; start bit begins in that same cycle.
- Frame length: 10×CICLOS_POR_BIT cycles (start + 8 data + stop).
- Back-to-back frames:
  - A transfer in the fin_trama cycle starts the next start bit on the following cycle.
  - Minimum nibble period is 10×CICLOS_POR_BIT+1 cycles.
- CICLOS_POR_BIT=1:
  - The cycle counter degenerates to zero width and is guarded to a minimum of 1 bit.
  - Each bit lasts exactly one cycle.

## Configuration
- INYECCION_ERROR_EN defined:
  - Port inyectar_error exists and is sampled at the transfer edge.
  - The transmitted and reported codeword is encoded word XOR mask.
  - Used to exercise the receiver's single/double error paths.
- Undefined: port absent; codeword always transmitted clean.

## Structure
- Package pkg_hamming:
  - Enum estado_tx_t {IDLE, INICIO, DATOS, PARADA}.
  - Bit-position constants IDX_P1=0, IDX_P2=1, IDX_D1=2, IDX_P4=3, IDX_D2=4, IDX_D3=5, IDX_D4=6, IDX_P0=7.
  - These constants are shared with the receive path.
- Sub-module module_codificador_hamming: combinational nibble → 8-bit codeword, reusable by testbenches as a reference model.

## Test plan
- Reset, then idle 20 cycles → tx_serie=1, entrada_lista=1, ocupado=0, palabra_codificada=8'h00.
- datos_entrada=4'b1011, N=4:
  - palabra_codificada=8'h55.
  - Line: 0 ×4 cycles, then 1,0,1,0,1,0,1,0 each ×4, then 1 ×4.
  - fin_trama pulses once, 41 cycles after the transfer edge.
- Nibbles 4'h0, 4'hF, 4'h1 back-to-back, entrada_valida held high → codewords 8'h00, 8'hFF, 8'h87; frames spaced exactly 41 cycles apart.
- entrada_valida pulsed with 4'h5 while ocupado=1 → not captured; frame in flight is unchanged.
- rst asserted during DATOS bit 3 → tx_serie=1 and ocupado=0 immediately; no fin_trama; next nibble is sent normally.
- With INYECCION_ERROR_EN: data 4'b1011, mask 8'h04 → palabra_codificada=8'h51 and serialized; the receiver flags error_simple and restores 8'h55.
